// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU (FORWARD/ADD/AND/OR) between two requesters.
// Round-robin grant, registered ALU operands/opcode, fixed settle wait, then
// a held response carrying the captured result and the owning requester ID.
// Ports:
//   CLK, RESET                  clock (rising edge), synchronous active-low reset
//   REQn_VALID/READY            requester n handshake (READY is combinational)
//   REQn_DATA1/DATA2/SELECT     requester n operands and opcode
//   RSP_VALID/READY             response handshake
//   RSP_ID/RESULT/ERR           response payload
//   ALU_DATA1/DATA2/SELECT      registered drive to the ALU
//   ALU_RESULT                  ALU output
//   BUSY                        arbiter not idle (combinational)
module alu_arbiter #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SEL_WIDTH     = 3,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned NUM_OPS       = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 REQ0_VALID,
    output logic                 REQ0_READY,
    input  logic [WIDTH-1:0]     REQ0_DATA1,
    input  logic [WIDTH-1:0]     REQ0_DATA2,
    input  logic [SEL_WIDTH-1:0] REQ0_SELECT,
    input  logic                 REQ1_VALID,
    output logic                 REQ1_READY,
    input  logic [WIDTH-1:0]     REQ1_DATA1,
    input  logic [WIDTH-1:0]     REQ1_DATA2,
    input  logic [SEL_WIDTH-1:0] REQ1_SELECT,
    output logic                 RSP_VALID,
    input  logic                 RSP_READY,
    output logic                 RSP_ID,
    output logic [WIDTH-1:0]     RSP_RESULT,
    output logic                 RSP_ERR,
    output logic [WIDTH-1:0]     ALU_DATA1,
    output logic [WIDTH-1:0]     ALU_DATA2,
    output logic [SEL_WIDTH-1:0] ALU_SELECT,
    input  logic [WIDTH-1:0]     ALU_RESULT,
    output logic                 BUSY
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 prio_q, prio_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_id_q, rsp_id_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0]     rsp_result_q, rsp_result_d;
    logic [WIDTH-1:0]     alu_d1_q, alu_d1_d;
    logic [WIDTH-1:0]     alu_d2_q, alu_d2_d;
    logic [SEL_WIDTH-1:0] alu_sel_q, alu_sel_d;

    // Grant selection: a lone requester wins, contention goes to PRIO
    logic                 any_valid;
    logic                 gnt_id;
    logic                 gnt_valid;
    logic [WIDTH-1:0]     gnt_d1;
    logic [WIDTH-1:0]     gnt_d2;
    logic [SEL_WIDTH-1:0] gnt_sel;
    logic                 gnt_legal;
    logic                 accept;

    assign any_valid = REQ0_VALID | REQ1_VALID;
    assign gnt_id    = (REQ0_VALID & REQ1_VALID) ? prio_q : REQ1_VALID;
    assign gnt_d1    = gnt_id ? REQ1_DATA1  : REQ0_DATA1;
    assign gnt_d2    = gnt_id ? REQ1_DATA2  : REQ0_DATA2;
    assign gnt_sel   = gnt_id ? REQ1_SELECT : REQ0_SELECT;
    assign gnt_legal = (32'(gnt_sel) < NUM_OPS);

    // Handshake only offered in IDLE and never while reset is asserted
    assign gnt_valid  = RESET & (state_q == IDLE) & any_valid;
    assign REQ0_READY = gnt_valid & ~gnt_id;
    assign REQ1_READY = gnt_valid &  gnt_id;
    assign accept     = gnt_valid;
    assign BUSY       = RESET & (state_q != IDLE);

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;
        rsp_result_d = rsp_result_q;
        alu_d1_d     = alu_d1_q;
        alu_d2_d     = alu_d2_q;
        alu_sel_d    = alu_sel_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    prio_d   = ~gnt_id;
                    rsp_id_d = gnt_id;
                    if (gnt_legal) begin
                        alu_d1_d  = gnt_d1;
                        alu_d2_d  = gnt_d2;
                        alu_sel_d = gnt_sel;
                        cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
                        state_d   = WAIT;
                    end else begin
                        // Illegal opcode: ALU left untouched, error returned at once
                        rsp_err_d    = 1'b1;
                        rsp_result_d = '0;
                        rsp_valid_d  = 1'b1;
                        state_d      = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_result_d = ALU_RESULT;
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= '0;
            alu_d1_q     <= '0;
            alu_d2_q     <= '0;
            alu_sel_q    <= '0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
            rsp_result_q <= rsp_result_d;
            alu_d1_q     <= alu_d1_d;
            alu_d2_q     <= alu_d2_d;
            alu_sel_q    <= alu_sel_d;
        end
    end

    assign RSP_VALID  = rsp_valid_q;
    assign RSP_ID     = rsp_id_q;
    assign RSP_ERR    = rsp_err_q;
    assign RSP_RESULT = rsp_result_q;
    assign ALU_DATA1  = alu_d1_q;
    assign ALU_DATA2  = alu_d2_q;
    assign ALU_SELECT = alu_sel_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a
// behavioural ALU (ADD settles in 2 ns, other ops in 1 ns).
module tb_alu_arbiter;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       REQ0_VALID = 1'b0;
    logic       REQ0_READY;
    logic [7:0] REQ0_DATA1 = '0;
    logic [7:0] REQ0_DATA2 = '0;
    logic [2:0] REQ0_SELECT = '0;
    logic       REQ1_VALID = 1'b0;
    logic       REQ1_READY;
    logic [7:0] REQ1_DATA1 = '0;
    logic [7:0] REQ1_DATA2 = '0;
    logic [2:0] REQ1_SELECT = '0;
    logic       RSP_VALID;
    logic       RSP_READY = 1'b0;
    logic       RSP_ID;
    logic [7:0] RSP_RESULT;
    logic       RSP_ERR;
    logic [7:0] ALU_DATA1;
    logic [7:0] ALU_DATA2;
    logic [2:0] ALU_SELECT;
    logic [7:0] ALU_RESULT = '0;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    alu_arbiter dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_READY (REQ0_READY),
        .REQ0_DATA1 (REQ0_DATA1),
        .REQ0_DATA2 (REQ0_DATA2),
        .REQ0_SELECT(REQ0_SELECT),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_READY (REQ1_READY),
        .REQ1_DATA1 (REQ1_DATA1),
        .REQ1_DATA2 (REQ1_DATA2),
        .REQ1_SELECT(REQ1_SELECT),
        .RSP_VALID  (RSP_VALID),
        .RSP_READY  (RSP_READY),
        .RSP_ID     (RSP_ID),
        .RSP_RESULT (RSP_RESULT),
        .RSP_ERR    (RSP_ERR),
        .ALU_DATA1  (ALU_DATA1),
        .ALU_DATA2  (ALU_DATA2),
        .ALU_SELECT (ALU_SELECT),
        .ALU_RESULT (ALU_RESULT),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    // Behavioural ALU with op-dependent settle delay
    always @(ALU_DATA1 or ALU_DATA2 or ALU_SELECT) begin
        case (ALU_SELECT)
            3'd1:    begin #2; ALU_RESULT = ALU_DATA1 + ALU_DATA2; end
            3'd2:    begin #1; ALU_RESULT = ALU_DATA1 & ALU_DATA2; end
            3'd3:    begin #1; ALU_RESULT = ALU_DATA1 | ALU_DATA2; end
            default: begin #1; ALU_RESULT = ALU_DATA1; end
        endcase
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        step();
        step();
        RESET = 1'b1;
    endtask

    task automatic wait_ready(input int id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((id == 0 && REQ0_READY) || (id == 1 && REQ1_READY)) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic wait_any(output int id, output bit ok);
        ok = 1'b0;
        id = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (REQ0_READY || REQ1_READY) begin
                ok = 1'b1;
                id = REQ1_READY ? 1 : 0;
                return;
            end
            step();
        end
    endtask

    task automatic wait_rsp(output bit ok, output int n);
        ok = 1'b0;
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if (RSP_VALID) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        REQ0_VALID = 1'b1;
        RESET = 1'b0;
        step();
        step();
        #1;
        checks++;
        if (REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_busy got r0=%b r1=%b busy=%b want 0 0 0", REQ0_READY, REQ1_READY, BUSY);
        end
        checks++;
        if ({RSP_VALID, RSP_ID, RSP_ERR, RSP_RESULT} !== 11'd0) begin
            errors++;
            $display("FAIL reset_rsp got v=%b id=%b err=%b res=%0h want all 0", RSP_VALID, RSP_ID, RSP_ERR, RSP_RESULT);
        end
        checks++;
        if ({ALU_DATA1, ALU_DATA2, ALU_SELECT} !== 19'd0) begin
            errors++;
            $display("FAIL reset_alu got d1=%0h d2=%0h sel=%0h want 0 0 0", ALU_DATA1, ALU_DATA2, ALU_SELECT);
        end
        REQ0_VALID = 1'b0;
        RESET = 1'b1;
    endtask

    task automatic test_add();
        bit ok;
        int n;
        RSP_READY = 1'b1;
        REQ0_DATA1 = 8'd3; REQ0_DATA2 = 8'd4; REQ0_SELECT = 3'b001; REQ0_VALID = 1'b1;
        wait_ready(0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL add_ready got timeout want REQ0_READY"); end
        step();
        REQ0_VALID = 1'b0;
        checks++;
        if (ALU_SELECT !== 3'b001 || ALU_DATA1 !== 8'd3 || ALU_DATA2 !== 8'd4 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL add_alu_drive got sel=%0h d1=%0h d2=%0h busy=%b want 1 3 4 1", ALU_SELECT, ALU_DATA1, ALU_DATA2, BUSY);
        end
        wait_rsp(ok, n);
        checks++;
        if (!ok || n != 2) begin errors++; $display("FAIL add_latency got ok=%b edges=%0d want 1 2", ok, n); end
        checks++;
        if (RSP_RESULT !== 8'd7 || RSP_ID !== 1'b0 || RSP_ERR !== 1'b0) begin
            errors++;
            $display("FAIL add_rsp got res=%0h id=%b err=%b want 7 0 0", RSP_RESULT, RSP_ID, RSP_ERR);
        end
        step();
        checks++;
        if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL add_release got v=%b busy=%b want 0 0", RSP_VALID, BUSY);
        end
    endtask

    task automatic test_contention();
        bit ok;
        int n;
        do_reset();
        RSP_READY = 1'b1;
        REQ0_DATA1 = 8'd4; REQ0_DATA2 = 8'd5; REQ0_SELECT = 3'd2; REQ0_VALID = 1'b1;
        REQ1_DATA1 = 8'd6; REQ1_DATA2 = 8'd7; REQ1_SELECT = 3'd3; REQ1_VALID = 1'b1;
        #1;
        checks++;
        if (REQ0_READY !== 1'b1 || REQ1_READY !== 1'b0) begin
            errors++;
            $display("FAIL cont_first_grant got r0=%b r1=%b want 1 0", REQ0_READY, REQ1_READY);
        end
        step();
        REQ0_VALID = 1'b0;
        wait_rsp(ok, n);
        checks++;
        if (!ok || RSP_RESULT !== 8'd4 || RSP_ID !== 1'b0) begin
            errors++;
            $display("FAIL cont_rsp0 got ok=%b res=%0h id=%b want 1 4 0", ok, RSP_RESULT, RSP_ID);
        end
        wait_ready(1, ok);
        step();
        REQ1_VALID = 1'b0;
        wait_rsp(ok, n);
        checks++;
        if (!ok || RSP_RESULT !== 8'd7 || RSP_ID !== 1'b1) begin
            errors++;
            $display("FAIL cont_rsp1 got ok=%b res=%0h id=%b want 1 7 1", ok, RSP_RESULT, RSP_ID);
        end
        step();
    endtask

    task automatic test_round_robin();
        bit ok;
        int n;
        int id;
        int want_id;
        logic [7:0] want_res;
        do_reset();
        RSP_READY = 1'b1;
        // REQ1's ADD overflows: 200+100 = 300, carry dropped -> 0x2C
        REQ0_DATA1 = 8'h5A; REQ0_DATA2 = 8'h00; REQ0_SELECT = 3'd0; REQ0_VALID = 1'b1;
        REQ1_DATA1 = 8'd200; REQ1_DATA2 = 8'd100; REQ1_SELECT = 3'd1; REQ1_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            want_id  = i % 2;
            want_res = (want_id == 0) ? 8'h5A : 8'h2C;
            wait_any(id, ok);
            checks++;
            if (!ok || id != want_id) begin
                errors++;
                $display("FAIL rr_grant%0d got ok=%b id=%0d want 1 %0d", i, ok, id, want_id);
            end
            step();
            if (i == 3) begin
                REQ0_VALID = 1'b0;
                REQ1_VALID = 1'b0;
            end
            wait_rsp(ok, n);
            checks++;
            if (!ok || RSP_ID !== 1'(want_id) || RSP_RESULT !== want_res) begin
                errors++;
                $display("FAIL rr_rsp%0d got ok=%b id=%b res=%0h want 1 %0d %0h", i, ok, RSP_ID, RSP_RESULT, want_id, want_res);
            end
        end
        step();
    endtask

    task automatic test_illegal();
        bit ok;
        RSP_READY = 1'b1;
        REQ1_DATA1 = 8'd9; REQ1_DATA2 = 8'd9; REQ1_SELECT = 3'b101; REQ1_VALID = 1'b1;
        wait_ready(1, ok);
        step();
        REQ1_VALID = 1'b0;
        checks++;
        if (!ok || RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1 || RSP_RESULT !== 8'd0 || RSP_ID !== 1'b1) begin
            errors++;
            $display("FAIL illegal_rsp got ok=%b v=%b err=%b res=%0h id=%b want 1 1 1 0 1", ok, RSP_VALID, RSP_ERR, RSP_RESULT, RSP_ID);
        end
        // ALU still holds the last legal op (REQ1 ADD 200,100)
        checks++;
        if (ALU_SELECT !== 3'd1 || ALU_DATA1 !== 8'd200 || ALU_DATA2 !== 8'd100) begin
            errors++;
            $display("FAIL illegal_alu_hold got sel=%0h d1=%0d d2=%0d want 1 200 100", ALU_SELECT, ALU_DATA1, ALU_DATA2);
        end
        step();
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        int bad;
        RSP_READY = 1'b0;
        REQ0_DATA1 = 8'hF0; REQ0_DATA2 = 8'h0F; REQ0_SELECT = 3'd3; REQ0_VALID = 1'b1;
        wait_ready(0, ok);
        step();
        REQ0_DATA1 = 8'd1; REQ0_DATA2 = 8'd1; REQ0_SELECT = 3'd1;
        wait_rsp(ok, n);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (RSP_VALID !== 1'b1 || RSP_RESULT !== 8'hFF || RSP_ID !== 1'b0 ||
                REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0 || BUSY !== 1'b1)
                bad++;
            step();
        end
        checks++;
        if (!ok || bad != 0) begin
            errors++;
            $display("FAIL bp_hold got ok=%b bad_cycles=%0d res=%0h want 1 0 ff", ok, bad, RSP_RESULT);
        end
        RSP_READY = 1'b1;
        step();
        #1;
        checks++;
        if (RSP_VALID !== 1'b0 || REQ0_READY !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got v=%b r0=%b want 0 1", RSP_VALID, REQ0_READY);
        end
        step();
        REQ0_VALID = 1'b0;
        wait_rsp(ok, n);
        checks++;
        if (!ok || RSP_RESULT !== 8'd2) begin
            errors++;
            $display("FAIL bp_second got ok=%b res=%0h want 1 2", ok, RSP_RESULT);
        end
        step();
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        int n;
        int seen;
        RSP_READY = 1'b1;
        REQ1_DATA1 = 8'd10; REQ1_DATA2 = 8'd20; REQ1_SELECT = 3'd1; REQ1_VALID = 1'b1;
        wait_ready(1, ok);
        step();
        REQ1_VALID = 1'b0;
        RESET = 1'b0;
        step();
        RESET = 1'b1;
        checks++;
        if (BUSY !== 1'b0 || RSP_VALID !== 1'b0 || RSP_ID !== 1'b0 || ALU_SELECT !== 3'd0 || ALU_DATA1 !== 8'd0) begin
            errors++;
            $display("FAIL rst_wait_state got busy=%b v=%b id=%b sel=%0h d1=%0h want 0 0 0 0 0", BUSY, RSP_VALID, RSP_ID, ALU_SELECT, ALU_DATA1);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (RSP_VALID) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_wait_no_rsp got %0d want 0", seen); end
        // A reset pulse that misses every edge must not disturb the operation
        REQ0_DATA1 = 8'd12; REQ0_DATA2 = 8'd10; REQ0_SELECT = 3'd2; REQ0_VALID = 1'b1;
        wait_ready(0, ok);
        step();
        REQ0_VALID = 1'b0;
        #1 RESET = 1'b0;
        #2 RESET = 1'b1;
        wait_rsp(ok, n);
        checks++;
        if (!ok || n != 2 || RSP_RESULT !== 8'd8 || RSP_ID !== 1'b0) begin
            errors++;
            $display("FAIL rst_glitch got ok=%b edges=%0d res=%0h id=%b want 1 2 8 0", ok, n, RSP_RESULT, RSP_ID);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_contention();
        test_round_robin();
        test_illegal();
        test_backpressure();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
